// File: rtl/gf_lfsr_pkg.sv
// Shared constants, feedback-form enum and per-width tap/polynomial tables
// for the GF(2^W) LFSR operand generator.
package gf_lfsr_pkg;

  localparam int unsigned W_MIN = 3;
  localparam int unsigned W_MAX = 8;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  // Fibonacci tap mask: feedback bit is the XOR of the masked state bits.
  function automatic logic [W_MAX-1:0] fib_tap(input int unsigned w);
    case (w)
      3:       return 8'b0000_0011;
      4:       return 8'b0000_0011;
      5:       return 8'b0000_0101;
      6:       return 8'b0000_0011;
      7:       return 8'b0000_0011;
      8:       return 8'b0001_1101;
      default: return '0;
    endcase
  endfunction

  // Galois mask XORed into the right-shifted state when the LSB falls out as 1.
  function automatic logic [W_MAX-1:0] gal_poly(input int unsigned w);
    case (w)
      3:       return 8'b0000_0101;
      4:       return 8'b0000_1001;
      5:       return 8'b0001_0010;
      6:       return 8'b0010_0001;
      7:       return 8'b0100_0001;
      8:       return 8'b1000_1110;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/gf_lfsr_step.sv
// Combinational one-step LFSR successor for a given width and feedback form.
module gf_lfsr_step
  import gf_lfsr_pkg::*;
#(
  parameter int unsigned W    = 3,
  parameter int unsigned MODE = 0
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] TAP  = W'(fib_tap(W));
  localparam logic [W-1:0] POLY = W'(gal_poly(W));
  localparam lfsr_mode_e   FORM = (MODE == 0) ? MODE_FIB : MODE_GAL;

  always_comb begin
    nxt = '0;
    if (FORM == MODE_FIB) begin
      nxt = {^(cur & TAP), cur[W-1:1]};
    end else begin
      nxt = (cur >> 1) ^ (cur[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/gf_lfsr_gen.sv
// GF(2^W) operand generator: LFSR stepped once per valid/ready transfer,
// with seed load, lock-up protection and cycle-period measurement.
module gf_lfsr_gen
  import gf_lfsr_pkg::*;
#(
  parameter int unsigned W    = 3,
  parameter int unsigned MODE = 0
) (
  input  logic         Clk,
  input  logic         nRst,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] seed,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         wrap,
  output logic [W-1:0] period,
  output logic         lockup_err
);

  if ((W < W_MIN) || (W > W_MAX) || (MODE > 1)) begin : g_param_check
    $error("gf_lfsr_gen: W must be 3..8 and MODE 0..1");
  end

  logic [W-1:0] state_q, state_d;
  logic [W-1:0] start_q, start_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic         lock_q, lock_d;
  logic [W-1:0] step_nxt;
  logic         xfer;

  gf_lfsr_step #(
    .W    (W),
    .MODE (MODE)
  ) u_step (
    .cur (state_q),
    .nxt (step_nxt)
  );

  assign xfer = valid_q & out_ready;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lock_d   = lock_q;
    wrap_d   = 1'b0;
    valid_d  = en | (valid_q & ~xfer);
    // A load overrides any coincident transfer: the presented word is simply
    // dropped and the loaded value is presented next without a step.
    if (ld) begin
      if (seed != '0) begin
        state_d = seed;
        start_d = seed;
        lock_d  = 1'b0;
      end else begin
        state_d = '1;
        start_d = '1;
        lock_d  = 1'b1;
      end
      cnt_d = '0;
    end else if (xfer) begin
      state_d = step_nxt;
      if (step_nxt == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state_q  <= '1;
      start_q  <= '1;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
    end
  end

  assign out_data   = state_q;
  assign out_valid  = valid_q;
  assign wrap       = wrap_q;
  assign period     = period_q;
  assign lockup_err = lock_q;

endmodule

// File: tb/tb_gf_lfsr_gen.sv
// Directed bench for gf_lfsr_gen: W=3 Fibonacci vector table plus W=3 Galois
// and W=8 full-period sequences, and a load/reset corner sequence.
module tb_gf_lfsr_gen;

  logic       Clk = 1'b0;
  logic       nRst, en, ld, rdy;
  logic [2:0] seed3;
  logic [7:0] seed8;

  logic [2:0] f3_data, f3_period, g3_data, g3_period;
  logic       f3_valid, f3_wrap, f3_lock, g3_valid, g3_wrap, g3_lock;
  logic [7:0] f8_data, f8_period, g8_data, g8_period;
  logic       f8_valid, f8_wrap, f8_lock, g8_valid, g8_wrap, g8_lock;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  gf_lfsr_gen #(.W(3), .MODE(0)) u_dut (
    .Clk(Clk), .nRst(nRst), .en(en), .ld(ld), .seed(seed3), .out_ready(rdy),
    .out_data(f3_data), .out_valid(f3_valid), .wrap(f3_wrap),
    .period(f3_period), .lockup_err(f3_lock)
  );
  gf_lfsr_gen #(.W(3), .MODE(1)) u_g3 (
    .Clk(Clk), .nRst(nRst), .en(en), .ld(ld), .seed(seed3), .out_ready(rdy),
    .out_data(g3_data), .out_valid(g3_valid), .wrap(g3_wrap),
    .period(g3_period), .lockup_err(g3_lock)
  );
  gf_lfsr_gen #(.W(8), .MODE(0)) u_f8 (
    .Clk(Clk), .nRst(nRst), .en(en), .ld(ld), .seed(seed8), .out_ready(rdy),
    .out_data(f8_data), .out_valid(f8_valid), .wrap(f8_wrap),
    .period(f8_period), .lockup_err(f8_lock)
  );
  gf_lfsr_gen #(.W(8), .MODE(1)) u_g8 (
    .Clk(Clk), .nRst(nRst), .en(en), .ld(ld), .seed(seed8), .out_ready(rdy),
    .out_data(g8_data), .out_valid(g8_valid), .wrap(g8_wrap),
    .period(g8_period), .lockup_err(g8_lock)
  );

  typedef struct {
    logic       en, ld, rdy;
    logic [2:0] seed;
    logic [2:0] d;
    logic       v, w;
    logic [2:0] p;
    logic       lk;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int e, input int l, input int s, input int r,
                     input int d, input int v, input int w, input int p,
                     input int lk);
    vec_t x;
    x.en = e[0]; x.ld = l[0]; x.seed = s[2:0]; x.rdy = r[0];
    x.d = d[2:0]; x.v = v[0]; x.w = w[0]; x.p = p[2:0]; x.lk = lk[0];
    vt.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    nRst = 1'b0; en = 1'b0; ld = 1'b0; rdy = 1'b1; seed3 = '0; seed8 = '0;
    step();
    step();
    nRst = 1'b1;
  endtask

  int         gal3_exp[8] = '{6, 3, 4, 2, 1, 5, 7, 6};
  bit         seen_f[256];
  bit         seen_g[256];
  int         dup_f, dup_g, wrap_at_f, wrap_at_g;

  initial begin
    // Fibonacci W=3 from reset: 7,3,1,4,2,5,6,7,...
    add(1,0,0,1, 7,1,0,0,0);
    add(1,0,0,1, 3,1,0,0,0);
    add(1,0,0,1, 1,1,0,0,0);
    add(1,0,0,1, 4,1,0,0,0);
    add(1,0,0,1, 2,1,0,0,0);
    add(1,0,0,1, 5,1,0,0,0);
    add(1,0,0,1, 6,1,0,0,0);
    add(1,0,0,1, 7,1,1,7,0);
    add(1,0,0,1, 3,1,0,7,0);
    for (int i = 0; i < 5; i++) add(1,0,0,0, 3,1,0,7,0);
    add(1,0,0,1, 1,1,0,7,0);
    // zero seed with a coincident transfer, then a real seed
    add(1,1,0,1, 7,1,0,7,1);
    add(1,0,0,1, 3,1,0,7,1);
    add(1,1,5,1, 5,1,0,7,0);
    add(1,0,0,1, 6,1,0,7,0);
    add(1,0,0,1, 7,1,0,7,0);
    add(1,0,0,1, 3,1,0,7,0);
    add(1,0,0,1, 1,1,0,7,0);
    add(1,0,0,1, 4,1,0,7,0);
    add(1,0,0,1, 2,1,0,7,0);
    add(1,0,0,1, 5,1,1,7,0);
    // final transfer with en low drops valid, then everything holds
    add(0,0,0,1, 6,0,0,7,0);
    add(0,0,0,1, 6,0,0,7,0);
    add(0,0,0,0, 6,0,0,7,0);

    do_reset();
    chk("rst_valid",  f3_valid, 0);
    chk("rst_data",   f3_data,  7);
    chk("rst_wrap",   f3_wrap,  0);
    chk("rst_period", f3_period, 0);
    chk("rst_lock",   f3_lock,  0);

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; ld = vt[i].ld; rdy = vt[i].rdy;
      seed3 = vt[i].seed; seed8 = {5'b0, vt[i].seed};
      step();
      chk($sformatf("vec%0d_data",   i), f3_data,   vt[i].d);
      chk($sformatf("vec%0d_valid",  i), f3_valid,  vt[i].v);
      chk($sformatf("vec%0d_wrap",   i), f3_wrap,   vt[i].w);
      chk($sformatf("vec%0d_period", i), f3_period, vt[i].p);
      chk($sformatf("vec%0d_lock",   i), f3_lock,   vt[i].lk);
    end
    ld = 1'b0;

    // W=3 Galois and W=8 both forms free-running from reset
    do_reset();
    en = 1'b1; rdy = 1'b1;
    step();
    chk("g3_first_valid", g3_valid, 1);
    chk("g3_first_data",  g3_data,  7);
    chk("f8_first_data",  f8_data,  255);
    chk("g8_first_data",  g8_data,  255);
    for (int k = 0; k < 256; k++) begin
      seen_f[k] = 1'b0;
      seen_g[k] = 1'b0;
    end
    seen_f[255] = 1'b1; seen_g[255] = 1'b1;
    dup_f = 0; dup_g = 0; wrap_at_f = 0; wrap_at_g = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i <= 8) begin
        chk($sformatf("g3_data%0d", i), g3_data, gal3_exp[i-1]);
        chk($sformatf("g3_wrap%0d", i), g3_wrap, (i == 7) ? 1 : 0);
      end
      if (i == 7) chk("g3_period", g3_period, 7);
      if (f8_wrap && wrap_at_f == 0) wrap_at_f = i;
      if (g8_wrap && wrap_at_g == 0) wrap_at_g = i;
      if (i < 255) begin
        if (seen_f[f8_data] || f8_data == 8'd0) dup_f++;
        if (seen_g[g8_data] || g8_data == 8'd0) dup_g++;
        seen_f[f8_data] = 1'b1;
        seen_g[g8_data] = 1'b1;
      end
    end
    chk("f8_distinct", dup_f, 0);
    chk("g8_distinct", dup_g, 0);
    chk("f8_wrap_at",  wrap_at_f, 255);
    chk("g8_wrap_at",  wrap_at_g, 255);
    chk("f8_return",   f8_data, 255);
    chk("g8_return",   g8_data, 255);
    chk("f8_period",   f8_period, 255);
    chk("g8_period",   g8_period, 255);

    // load coincident with a transfer, then reset mid-sequence
    do_reset();
    en = 1'b1; rdy = 1'b1;
    step();
    step();
    chk("ldx_pre_data", f3_data, 3);
    ld = 1'b1; seed3 = 3'd4;
    step();
    chk("ldx_data",  f3_data,  4);
    chk("ldx_valid", f3_valid, 1);
    ld = 1'b0; nRst = 1'b0;
    step();
    chk("midrst_valid",  f3_valid,  0);
    chk("midrst_data",   f3_data,   7);
    chk("midrst_wrap",   f3_wrap,   0);
    chk("midrst_period", f3_period, 0);
    nRst = 1'b1; en = 1'b0;
    step();
    chk("post_rst_valid", f3_valid, 0);
    chk("post_rst_data",  f3_data,  7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
